// File: rtl/fetch_unit.sv
// fetch_unit: program counter, next-PC select and run/halt/fault control.
// Drives the instruction-memory address and counts retired instructions.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IMEM_BYTES   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] LIMIT  = 32'(IMEM_BYTES - 4);

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nx;
  logic [31:0] r_retired;
  logic [31:0] w_retired_nx;
  logic        r_halted;
  logic        r_fault;
  logic [31:0] w_sel;
  logic        w_bad;
  logic        w_go;

  assign pc       = r_pc;
  assign pc_plus4 = r_pc + 32'd4;
  assign retired  = r_retired;
  assign halted   = r_halted;
  assign fault    = r_fault;
  assign w_go     = (r_state == RUN) && !stall;
  assign valid    = w_go;

  // Next-PC mux; jalr target has bit 0 forced low.
  always_comb begin
    w_sel = pc_plus4;
    unique case (pc_src)
      2'b01:   w_sel = branch_target;
      2'b10:   w_sel = {jalr_target[31:1], 1'b0};
      default: w_sel = pc_plus4;
    endcase
  end

  assign w_bad = (w_sel[1:0] != 2'b00) || (w_sel > LIMIT);

  // Next state, PC and retire count; stall > ebreak > fault > advance.
  always_comb begin
    w_state_nx   = r_state;
    w_pc_nx      = r_pc;
    w_retired_nx = r_retired;
    unique case (r_state)
      BOOT: w_state_nx = RUN;
      RUN: begin
        if (!stall) begin
          if (instr == EBREAK) begin
            w_state_nx = HALT;
          end else if (w_bad) begin
            w_state_nx   = FAULT;
            w_retired_nx = r_retired + 32'd1;
          end else begin
            w_pc_nx      = w_sel;
            w_retired_nx = r_retired + 32'd1;
          end
        end
      end
      HALT:    w_state_nx = HALT;
      FAULT:   w_state_nx = FAULT;
      default: w_state_nx = BOOT;
    endcase
  end

  // State and architectural registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= BOOT;
      r_pc      <= RESET_VECTOR;
      r_retired <= 32'd0;
      r_halted  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pc      <= w_pc_nx;
      r_retired <= w_retired_nx;
      r_halted  <= (w_state_nx == HALT);
      r_fault   <= (w_state_nx == FAULT);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for fetch_unit.
// Second instance covers pc_plus4 wrap at the top of the address space.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;
  logic [31:0] instr;
  logic [31:0] pc, pc_plus4, retired;
  logic        valid, halted, fault;
  logic [31:0] w_pc, w_pc_plus4, w_retired;
  logic        w_valid, w_halted, w_fault;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBK = 32'h0010_0073;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
    .branch_target(branch_target), .jalr_target(jalr_target),
    .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .valid(valid),
    .halted(halted), .fault(fault), .retired(retired)
  );

  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
    .branch_target(branch_target), .jalr_target(jalr_target),
    .instr(instr), .pc(w_pc), .pc_plus4(w_pc_plus4), .valid(w_valid),
    .halted(w_halted), .fault(w_fault), .retired(w_retired)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input string tag, input logic [31:0] epc,
                      input logic [31:0] eret, input logic ev,
                      input logic eh, input logic ef);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".ret"}, retired, eret);
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".halt"}, 32'(halted), 32'(eh));
    chk({tag, ".fault"}, 32'(fault), 32'(ef));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; pc_src = 2'b00;
    branch_target = '0; jalr_target = '0; instr = NOP;
    #2;

    // Sequential run to the end of memory.
    do_reset();
    snap("boot", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("wrap.p4", w_pc_plus4, 32'd0);
    chk("wrap.pc", w_pc, 32'hFFFF_FFFC);
    step(); snap("run0", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("run0.p4", pc_plus4, 32'd4);
    step(); snap("run4", 32'd4, 32'd1, 1'b1, 1'b0, 1'b0);
    step(); snap("run8", 32'd8, 32'd2, 1'b1, 1'b0, 1'b0);
    step(); snap("run12", 32'd12, 32'd3, 1'b1, 1'b0, 1'b0);
    chk("run12.p4", pc_plus4, 32'd16);
    step(); snap("oor", 32'd12, 32'd4, 1'b0, 1'b0, 1'b1);
    pc_src = 2'b01;
    step(); step();
    snap("oor.hold", 32'd12, 32'd4, 1'b0, 1'b0, 1'b1);

    // Reset out of FAULT, then branch / jalr / misaligned.
    pc_src = 2'b00;
    do_reset();
    snap("rstf", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(); step(); step(); step();
    snap("b.at12", 32'd12, 32'd3, 1'b1, 1'b0, 1'b0);
    pc_src = 2'b01; branch_target = 32'd0;
    step(); snap("br0", 32'd0, 32'd4, 1'b1, 1'b0, 1'b0);
    pc_src = 2'b10; jalr_target = 32'h9;
    step(); snap("jalr9", 32'd8, 32'd5, 1'b1, 1'b0, 1'b0);
    pc_src = 2'b01; branch_target = 32'h6;
    step(); snap("mis", 32'd8, 32'd6, 1'b0, 1'b0, 1'b1);

    // Stall holds pc and count; reset wins over stall.
    pc_src = 2'b00;
    do_reset();
    step(); step();
    snap("s.at4", 32'd4, 32'd1, 1'b1, 1'b0, 1'b0);
    stall = 1'b1; pc_src = 2'b01; branch_target = 32'd12;
    #1;
    chk("s.valid0", 32'(valid), 32'd0);
    for (int i = 0; i < 3; i++) step();
    snap("s.hold", 32'd4, 32'd1, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    #1;
    chk("s.valid1", 32'(valid), 32'd1);
    step(); snap("s.go", 32'd12, 32'd2, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    do_reset();
    stall = 1'b0;
    snap("rsts", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // pc_src=11 behaves as pc+4; EBREAK halts permanently.
    pc_src = 2'b00;
    step(); step();
    pc_src = 2'b11;
    step(); snap("src11", 32'd8, 32'd2, 1'b1, 1'b0, 1'b0);
    instr = EBK;
    step(); snap("halt", 32'd8, 32'd2, 1'b0, 1'b1, 1'b0);
    instr = NOP;
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      pc_src = i[1:0];
      branch_target = 32'd4;
      step();
    end
    stall = 1'b0;
    snap("halt10", 32'd8, 32'd2, 1'b0, 1'b1, 1'b0);
    do_reset();
    snap("rsth", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(); snap("rsth.run", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
